l2_cache_responder: RTL and testbench

- Unified, set-associative, write-back L2 cache. Services single-word read/write requests from the L1 cache controller over the L1↔L2 request/ready/hit handshake.
- Acts as initiator toward main memory on misses and dirty evictions.
- One DATA_WIDTH word per line. Byte offset selects no data and is zeroed on memory addresses.

---
 rtl/l2_cache_responder.sv | 278 +++++++++++++++++++++++++++
 tb/tb_l2_cache_responder.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/l2_cache_responder.sv
// l2_cache_responder
// Unified, set-associative, write-back L2 cache holding one DATA_WIDTH word
// per line. Serves single-word reads/writes from the L1 controller and acts
// as initiator toward main memory for line fills and dirty evictions.
//
// Ports:
//   clk, rst          - clock (posedge) and synchronous active-high reset
//   l1_addr           - request address from L1
//   l1_data_in        - write data from L1
//   l1_data_out       - read data to L1, held until the next read response
//   l1_read/l1_write  - level requests, held until l1_ready
//   l1_ready          - one-cycle completion pulse
//   l1_hit            - qualified by l1_ready; 1 = request hit in L2
//   mem_addr          - line-aligned memory address (offset bits zero)
//   mem_data_out      - write-back data
//   mem_data_in       - fill data
//   mem_read/mem_write- memory requests, held until mem_ready
//   mem_ready         - memory completion
module l2_cache_responder #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int CACHE_SIZE = 4096,
    parameter int BLOCK_SIZE = 16,
    parameter int NUM_WAYS   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] l1_addr,
    input  logic [DATA_WIDTH-1:0] l1_data_in,
    output logic [DATA_WIDTH-1:0] l1_data_out,
    input  logic                  l1_read,
    input  logic                  l1_write,
    output logic                  l1_ready,
    output logic                  l1_hit,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_data_out,
    input  logic [DATA_WIDTH-1:0] mem_data_in,
    output logic                  mem_read,
    output logic                  mem_write,
    input  logic                  mem_ready
);
    localparam int NUM_SETS = CACHE_SIZE / BLOCK_SIZE / NUM_WAYS;
    localparam int OFF_W    = $clog2(BLOCK_SIZE);
    localparam int IDX_W    = $clog2(NUM_SETS);
    localparam int LINE_W   = ADDR_WIDTH - OFF_W;
    localparam int TAG_W    = LINE_W - IDX_W;
    localparam int WAY_W    = $clog2(NUM_WAYS);

    typedef enum logic [1:0] {
        S_IDLE       = 2'd0,
        S_COMPARE    = 2'd1,
        S_WRITE_BACK = 2'd2,
        S_ALLOCATE   = 2'd3
    } state_t;

    // Lowest-index set bit of a way vector (0 when the vector is empty).
    function automatic logic [WAY_W-1:0] first_set(input logic [NUM_WAYS-1:0] vec);
        logic [WAY_W-1:0] idx;
        idx = '0;
        for (int w = NUM_WAYS - 1; w >= 0; w--) begin
            if (vec[w]) begin
                idx = WAY_W'(w);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    // Line storage and per-set round-robin pointers
    logic [TAG_W-1:0]      tag_q   [NUM_SETS][NUM_WAYS];
    logic [DATA_WIDTH-1:0] data_q  [NUM_SETS][NUM_WAYS];
    logic [NUM_WAYS-1:0]   valid_q [NUM_SETS];
    logic [NUM_WAYS-1:0]   dirty_q [NUM_SETS];
    logic [WAY_W-1:0]      ptr_q   [NUM_SETS];

    // Control state and registered outputs
    state_t                state_q, state_d;
    logic [LINE_W-1:0]     line_q, line_d;          // latched line address
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  is_wr_q, is_wr_d;
    logic [WAY_W-1:0]      victim_q, victim_d;
    logic                  victim_valid_q, victim_valid_d;
    logic                  l1_ready_q, l1_ready_d;
    logic                  l1_hit_q, l1_hit_d;
    logic [DATA_WIDTH-1:0] l1_data_out_q, l1_data_out_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_data_out_q, mem_data_out_d;
    logic                  mem_read_q, mem_read_d;
    logic                  mem_write_q, mem_write_d;

    // Storage update requests from the next-state logic
    logic                  line_we_s;
    logic [WAY_W-1:0]      line_way_s;
    logic [DATA_WIDTH-1:0] line_data_s;
    logic                  line_dirty_s;
    logic                  ptr_inc_s;

    logic [IDX_W-1:0]      req_idx_s;
    logic [TAG_W-1:0]      req_tag_s;
    logic [NUM_WAYS-1:0]   hit_vec_s;
    logic                  hit_s;
    logic [WAY_W-1:0]      hit_way_s;
    logic [WAY_W-1:0]      victim_s;
    logic                  victim_valid_s;

    // Byte offset selects nothing in a one-word line
    logic unused_offset_s;
    assign unused_offset_s = ^l1_addr[OFF_W-1:0];

    assign req_idx_s = line_q[IDX_W-1:0];
    assign req_tag_s = line_q[LINE_W-1 -: TAG_W];

    // Tag compare and victim choice for the latched request
    always_comb begin
        for (int w = 0; w < NUM_WAYS; w++) begin
            hit_vec_s[w] = valid_q[req_idx_s][w] && (tag_q[req_idx_s][w] == req_tag_s);
        end
        hit_s     = |hit_vec_s;
        hit_way_s = first_set(hit_vec_s);
        // Fill an empty way first; only a full set consults the pointer
        if (~&valid_q[req_idx_s]) begin
            victim_s       = first_set(~valid_q[req_idx_s]);
            victim_valid_s = 1'b0;
        end else begin
            victim_s       = ptr_q[req_idx_s];
            victim_valid_s = 1'b1;
        end
    end

    // Next-state and next-output logic of the controller
    always_comb begin
        state_d        = state_q;
        line_d         = line_q;
        wdata_d        = wdata_q;
        is_wr_d        = is_wr_q;
        victim_d       = victim_q;
        victim_valid_d = victim_valid_q;
        l1_ready_d     = 1'b0;
        l1_hit_d       = 1'b0;
        l1_data_out_d  = l1_data_out_q;
        mem_addr_d     = mem_addr_q;
        mem_data_out_d = mem_data_out_q;
        mem_read_d     = mem_read_q;
        mem_write_d    = mem_write_q;
        line_we_s      = 1'b0;
        line_way_s     = hit_way_s;
        line_data_s    = wdata_q;
        line_dirty_s   = 1'b1;
        ptr_inc_s      = 1'b0;
        case (state_q)
            S_IDLE: begin
                // l1_ready_q high means the held request was just answered
                if ((l1_read || l1_write) && !l1_ready_q) begin
                    line_d  = l1_addr[ADDR_WIDTH-1:OFF_W];
                    wdata_d = l1_data_in;
                    is_wr_d = l1_write;
                    state_d = S_COMPARE;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COMPARE: begin
                if (hit_s) begin
                    l1_ready_d = 1'b1;
                    l1_hit_d   = 1'b1;
                    state_d    = S_IDLE;
                    if (is_wr_q) begin
                        line_we_s = 1'b1;
                    end else begin
                        l1_data_out_d = data_q[req_idx_s][hit_way_s];
                    end
                end else begin
                    victim_d       = victim_s;
                    victim_valid_d = victim_valid_s;
                    if (victim_valid_s && dirty_q[req_idx_s][victim_s]) begin
                        mem_write_d    = 1'b1;
                        mem_addr_d     = {tag_q[req_idx_s][victim_s], req_idx_s, {OFF_W{1'b0}}};
                        mem_data_out_d = data_q[req_idx_s][victim_s];
                        state_d        = S_WRITE_BACK;
                    end else begin
                        mem_read_d = 1'b1;
                        mem_addr_d = {line_q, {OFF_W{1'b0}}};
                        state_d    = S_ALLOCATE;
                    end
                end
            end
            S_WRITE_BACK: begin
                if (mem_ready) begin
                    mem_write_d = 1'b0;
                    mem_read_d  = 1'b1;
                    mem_addr_d  = {line_q, {OFF_W{1'b0}}};
                    state_d     = S_ALLOCATE;
                end else begin
                    state_d = S_WRITE_BACK;
                end
            end
            S_ALLOCATE: begin
                if (mem_ready) begin
                    mem_read_d   = 1'b0;
                    line_we_s    = 1'b1;
                    line_way_s   = victim_q;
                    line_dirty_s = is_wr_q;
                    ptr_inc_s    = victim_valid_q;
                    l1_ready_d   = 1'b1;
                    state_d      = S_IDLE;
                    if (is_wr_q) begin
                        line_data_s = wdata_q;
                    end else begin
                        line_data_s   = mem_data_in;
                        l1_data_out_d = mem_data_in;
                    end
                end else begin
                    state_d = S_ALLOCATE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, output and storage registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            line_q         <= '0;
            wdata_q        <= '0;
            is_wr_q        <= 1'b0;
            victim_q       <= '0;
            victim_valid_q <= 1'b0;
            l1_ready_q     <= 1'b0;
            l1_hit_q       <= 1'b0;
            l1_data_out_q  <= '0;
            mem_addr_q     <= '0;
            mem_data_out_q <= '0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            for (int s = 0; s < NUM_SETS; s++) begin
                valid_q[s] <= '0;
                dirty_q[s] <= '0;
                ptr_q[s]   <= '0;
            end
        end else begin
            state_q        <= state_d;
            line_q         <= line_d;
            wdata_q        <= wdata_d;
            is_wr_q        <= is_wr_d;
            victim_q       <= victim_d;
            victim_valid_q <= victim_valid_d;
            l1_ready_q     <= l1_ready_d;
            l1_hit_q       <= l1_hit_d;
            l1_data_out_q  <= l1_data_out_d;
            mem_addr_q     <= mem_addr_d;
            mem_data_out_q <= mem_data_out_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            if (line_we_s) begin
                tag_q[req_idx_s][line_way_s]   <= req_tag_s;
                data_q[req_idx_s][line_way_s]  <= line_data_s;
                valid_q[req_idx_s][line_way_s] <= 1'b1;
                dirty_q[req_idx_s][line_way_s] <= line_dirty_s;
            end
            if (ptr_inc_s) begin
                ptr_q[req_idx_s] <= ptr_q[req_idx_s] + WAY_W'(1);
            end
        end
    end

    assign l1_ready     = l1_ready_q;
    assign l1_hit       = l1_hit_q;
    assign l1_data_out  = l1_data_out_q;
    assign mem_addr     = mem_addr_q;
    assign mem_data_out = mem_data_out_q;
    assign mem_read     = mem_read_q;
    assign mem_write    = mem_write_q;

endmodule

// File: tb/tb_l2_cache_responder.sv
// Directed bench for l2_cache_responder with a fixed-latency memory model.
module tb_l2_cache_responder;
    localparam int MEM_LAT = 3;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] l1_addr, l1_data_in, l1_data_out;
    logic        l1_read, l1_write, l1_ready, l1_hit;
    logic [31:0] mem_addr, mem_data_out;
    logic [31:0] mem_data_in = 32'h0;
    logic        mem_read, mem_write;
    logic        mem_ready = 1'b0;

    int n_vec = 0;
    int n_miss = 0;

    // memory model bookkeeping
    logic [31:0] mem_model [logic [31:0]];
    int          mem_cnt = 0;
    int          rd_cnt = 0, wr_cnt = 0, ev_seq = 0, rd_seq = 0, wr_seq = 0, both_hi = 0;
    logic [31:0] rd_addr = 32'h0, wr_addr = 32'h0, wr_data = 32'h0;

    l2_cache_responder dut (
        .clk          (clk),
        .rst          (rst),
        .l1_addr      (l1_addr),
        .l1_data_in   (l1_data_in),
        .l1_data_out  (l1_data_out),
        .l1_read      (l1_read),
        .l1_write     (l1_write),
        .l1_ready     (l1_ready),
        .l1_hit       (l1_hit),
        .mem_addr     (mem_addr),
        .mem_data_out (mem_data_out),
        .mem_data_in  (mem_data_in),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .mem_ready    (mem_ready)
    );

    always #5 clk = ~clk;

    // Backing-store contents for lines never written back
    function automatic logic [31:0] mem_default(input logic [31:0] a);
        if (a == 32'h0000_1000) return 32'hDEAD_BEEF;
        else return a ^ 32'hC0DE_0000;
    endfunction

    // Memory responder: ready pulses MEM_LAT cycles after a request appears
    always @(negedge clk) begin
        if (mem_read && mem_write) both_hi++;
        if (mem_ready) begin
            mem_ready = 1'b0;
            mem_cnt   = 0;
        end else if (mem_read || mem_write) begin
            if (mem_cnt == MEM_LAT - 1) begin
                mem_ready = 1'b1;
                mem_cnt   = 0;
                ev_seq++;
                if (mem_write) begin
                    wr_cnt++;
                    wr_addr = mem_addr;
                    wr_data = mem_data_out;
                    wr_seq  = ev_seq;
                    mem_model[mem_addr] = mem_data_out;
                end else begin
                    rd_cnt++;
                    rd_addr = mem_addr;
                    rd_seq  = ev_seq;
                    mem_data_in = mem_model.exists(mem_addr) ? mem_model[mem_addr] : mem_default(mem_addr);
                end
            end else begin
                mem_cnt++;
            end
        end else begin
            mem_cnt = 0;
        end
    end

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; l1_read = 1'b0; l1_write = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_reset();
        check_vec("rst_l1_ready", 32'(l1_ready), 32'd0);
        check_vec("rst_l1_hit", 32'(l1_hit), 32'd0);
        check_vec("rst_mem_read", 32'(mem_read), 32'd0);
        check_vec("rst_mem_write", 32'(mem_write), 32'd0);
        check_vec("rst_l1_data_out", l1_data_out, 32'h0);
        check_vec("rst_mem_addr", mem_addr, 32'h0);
        check_vec("rst_mem_data_out", mem_data_out, 32'h0);
    endtask

    // One L1 request; inputs are scrambled after acceptance to prove they are latched
    task automatic do_req(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                          output logic [31:0] rdata, output logic hit, output int lat,
                          output int rdn, output int wrn);
        int  rd0, wr0;
        logic done;
        @(negedge clk);
        rd0 = rd_cnt; wr0 = wr_cnt;
        l1_read = ~wr; l1_write = wr; l1_addr = addr; l1_data_in = wd;
        lat = 0; done = 1'b0;
        while (!done && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            if (lat == 1) begin
                l1_addr = ~addr; l1_data_in = ~wd;
            end
            if (l1_ready) done = 1'b1;
        end
        if (!done) check_vec("req_timeout", 32'(done), 32'd1);
        rdata = l1_data_out; hit = l1_hit;
        rdn = rd_cnt - rd0; wrn = wr_cnt - wr0;
        l1_read = 1'b0; l1_write = 1'b0;
    endtask

    initial begin
        logic [31:0] rd;
        logic        h;
        int          lat, rn, wn, wsum, k;
        logic        seen;
        rst = 1'b1; l1_read = 1'b0; l1_write = 1'b0; l1_addr = 32'h0; l1_data_in = 32'h0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_reset();

        // 1: cold read miss then hit
        do_req(1'b0, 32'h0000_1000, 32'h0, rd, h, lat, rn, wn);
        check_vec("t1_miss_data", rd, 32'hDEAD_BEEF);
        check_vec("t1_miss_hit", 32'(h), 32'd0);
        check_vec("t1_miss_rdn", rn, 32'd1);
        check_vec("t1_miss_rdaddr", rd_addr, 32'h0000_1000);
        check_vec("t1_miss_wrn", wn, 32'd0);
        do_req(1'b0, 32'h0000_1000, 32'h0, rd, h, lat, rn, wn);
        check_vec("t1_hit_hit", 32'(h), 32'd1);
        check_vec("t1_hit_lat", lat, 32'd2);
        check_vec("t1_hit_data", rd, 32'hDEAD_BEEF);
        check_vec("t1_hit_rdn", rn, 32'd0);

        // 2: offset zeroing on a cold cache
        do_reset();
        check_reset();
        do_req(1'b0, 32'h0000_1004, 32'h0, rd, h, lat, rn, wn);
        check_vec("t2_rdaddr", rd_addr, 32'h0000_1000);
        check_vec("t2_data", rd, 32'hDEAD_BEEF);
        check_vec("t2_hit", 32'(h), 32'd0);

        // 3: write miss into a clean way, then read hit
        do_reset();
        do_req(1'b1, 32'h0000_2000, 32'h55AA_55AA, rd, h, lat, rn, wn);
        check_vec("t3_wr_wrn", wn, 32'd0);
        check_vec("t3_wr_rdn", rn, 32'd1);
        check_vec("t3_wr_rdaddr", rd_addr, 32'h0000_2000);
        check_vec("t3_wr_hit", 32'(h), 32'd0);
        do_req(1'b0, 32'h0000_2000, 32'h0, rd, h, lat, rn, wn);
        check_vec("t3_rd_hit", 32'(h), 32'd1);
        check_vec("t3_rd_data", rd, 32'h55AA_55AA);
        check_vec("t3_rd_lat", lat, 32'd2);

        // 4: dirty eviction of way 0 in set 0
        do_reset();
        do_req(1'b1, 32'h0000_0000, 32'h1111_1111, rd, h, lat, rn, wn);
        wsum = 0;
        for (int i = 1; i < 4; i++) begin
            do_req(1'b0, 32'(i * 32'h400), 32'h0, rd, h, lat, rn, wn);
            wsum += wn;
        end
        check_vec("t4_fill_wrn", wsum, 32'd0);
        do_req(1'b0, 32'h0000_1000, 32'h0, rd, h, lat, rn, wn);
        check_vec("t4_wrn", wn, 32'd1);
        check_vec("t4_wraddr", wr_addr, 32'h0000_0000);
        check_vec("t4_wrdata", wr_data, 32'h1111_1111);
        check_vec("t4_rdn", rn, 32'd1);
        check_vec("t4_rdaddr", rd_addr, 32'h0000_1000);
        check_vec("t4_wb_first", 32'(wr_seq < rd_seq), 32'd1);
        check_vec("t4_data", rd, 32'hDEAD_BEEF);
        check_vec("t4_hit", 32'(h), 32'd0);

        // 5: round-robin over a full clean set (ways 0..3 = 0x0,0x1000,0x400,0x800)
        do_reset();
        do_req(1'b0, 32'h0000_0000, 32'h0, rd, h, lat, rn, wn);
        do_req(1'b0, 32'h0000_1000, 32'h0, rd, h, lat, rn, wn);
        do_req(1'b0, 32'h0000_0400, 32'h0, rd, h, lat, rn, wn);
        do_req(1'b0, 32'h0000_0800, 32'h0, rd, h, lat, rn, wn);
        do_req(1'b0, 32'h0000_1400, 32'h0, rd, h, lat, rn, wn);
        check_vec("t5_1400_hit", 32'(h), 32'd0);
        do_req(1'b0, 32'h0000_1800, 32'h0, rd, h, lat, rn, wn);
        check_vec("t5_1800_hit", 32'(h), 32'd0);
        check_vec("t5_1800_wrn", wn, 32'd0);
        do_req(1'b0, 32'h0000_0400, 32'h0, rd, h, lat, rn, wn);
        check_vec("t5_0400_rehit", 32'(h), 32'd1);
        do_req(1'b0, 32'h0000_0800, 32'h0, rd, h, lat, rn, wn);
        check_vec("t5_0800_rehit", 32'(h), 32'd1);
        do_req(1'b0, 32'h0000_1800, 32'h0, rd, h, lat, rn, wn);
        check_vec("t5_1800_rehit", 32'(h), 32'd1);
        do_req(1'b0, 32'h0000_0000, 32'h0, rd, h, lat, rn, wn);
        check_vec("t5_0000_remiss", 32'(h), 32'd0);
        check_vec("t5_0000_rdn", rn, 32'd1);

        // 6: reset while a write-back is outstanding
        do_reset();
        do_req(1'b1, 32'h0000_3000, 32'hABCD_0123, rd, h, lat, rn, wn);
        for (int i = 1; i < 4; i++) do_req(1'b0, 32'(i * 32'h400), 32'h0, rd, h, lat, rn, wn);
        k = wr_cnt;
        @(negedge clk);
        l1_read = 1'b1; l1_addr = 32'h0000_1000;
        seen = 1'b0;
        for (int i = 0; i < 50 && !seen; i++) begin
            @(negedge clk);
            if (mem_write) seen = 1'b1;
        end
        check_vec("t6_wb_started", 32'(seen), 32'd1);
        rst = 1'b1; l1_read = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_vec("t6_mem_write_drop", 32'(mem_write), 32'd0);
        check_vec("t6_mem_read_low", 32'(mem_read), 32'd0);
        check_vec("t6_l1_ready_low", 32'(l1_ready), 32'd0);
        do_req(1'b0, 32'h0000_3000, 32'h0, rd, h, lat, rn, wn);
        check_vec("t6_reread_hit", 32'(h), 32'd0);
        check_vec("t6_reread_data", rd, 32'h0000_3000 ^ 32'hC0DE_0000);
        check_vec("t6_no_writeback", wr_cnt - k, 32'd0);

        check_vec("mem_rd_wr_exclusive", both_hi, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
